// File: rtl/sm83_pkg.sv
// Shared types and defaults for the SM83 core control path.
package sm83_pkg;

    typedef enum logic [2:0] {
        S_BOOT,
        S_FETCH,
        S_EXEC,
        S_INT,
        S_HALT
    } seq_state_t;

    localparam int INT_MCYCLES_DEF = 5;
    localparam int T_PER_M_DEF     = 4;

endpackage

// File: rtl/sm83_tstate_ctr.sv
// T-state counter: divides clk into M-cycles, stalls the last T-state while the bus is not ready.
module sm83_tstate_ctr
    import sm83_pkg::*;
#(
    parameter int T_PER_M = T_PER_M_DEF,
    parameter int T_W     = ($clog2(T_PER_M) > 0) ? $clog2(T_PER_M) : 1
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           i_bus_ready,
    output logic [T_W-1:0] o_tstate,
    output logic           o_strobe
);

    localparam logic [T_W-1:0] T_LAST = T_W'(T_PER_M - 1);

    logic [T_W-1:0] tstate_q;

    // With T_PER_M == 1 the index never leaves 0 and the strobe is just ready.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tstate_q <= '0;
        end else if (tstate_q != T_LAST) begin
            tstate_q <= tstate_q + T_W'(1);
        end else if (i_bus_ready) begin
            tstate_q <= '0;
        end
    end

    assign o_tstate = tstate_q;
    assign o_strobe = (tstate_q == T_LAST) & i_bus_ready;

endmodule

// File: rtl/sm83_mcycle_seq.sv
// M-cycle sequencer: fetch/execute overlap, interrupt dispatch and HALT, advanced on each M-cycle strobe.
module sm83_mcycle_seq
    import sm83_pkg::*;
#(
    parameter int T_PER_M     = T_PER_M_DEF,
    parameter int MAX_MCYC    = 6,
    parameter int INT_MCYCLES = INT_MCYCLES_DEF,
    parameter int MCYC_W      = $clog2(MAX_MCYC + 1),
    parameter int T_W         = ($clog2(T_PER_M) > 0) ? $clog2(T_PER_M) : 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_bus_ready,
    input  logic [MCYC_W-1:0] i_mcycles,
    input  logic              i_halt_req,
    input  logic              i_int_pending,
    input  logic              i_ime,
    output logic [T_W-1:0]    o_tstate,
    output logic              o_mcycle_strobe,
    output logic              o_fetch_cycle,
    output logic              o_execute_cycle,
    output logic              o_execute_last,
    output logic [MCYC_W-1:0] o_mcycle_idx,
    output logic              o_int_dispatch,
    output logic              o_halted
);

    seq_state_t        state_q, state_d;
    logic [MCYC_W-1:0] idx_q, idx_d;
    logic [MCYC_W-1:0] n_q, n_d, n_new;
    logic              halt_q, halt_d;
    logic              strobe;
    logic              start_instr;

    function automatic logic [MCYC_W-1:0] sat_mcycles(input logic [MCYC_W-1:0] raw);
        if (raw == '0) return MCYC_W'(1);
        if (int'(raw) > MAX_MCYC) return MCYC_W'(MAX_MCYC);
        return raw;
    endfunction

    sm83_tstate_ctr #(
        .T_PER_M (T_PER_M),
        .T_W     (T_W)
    ) u_tstate_ctr (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_bus_ready (i_bus_ready),
        .o_tstate    (o_tstate),
        .o_strobe    (strobe)
    );

    assign n_new = sat_mcycles(i_mcycles);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_BOOT;
            idx_q   <= '0;
            n_q     <= MCYC_W'(1);
            halt_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            n_q     <= n_d;
            halt_q  <= halt_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        n_d         = n_q;
        halt_d      = halt_q;
        start_instr = 1'b0;
        if (strobe) begin
            case (state_q)
                S_BOOT: begin
                    halt_d      = halt_q | i_halt_req;
                    start_instr = 1'b1;
                end
                S_FETCH: begin
                    // An interrupt pre-empts a pending HALT; either one discards the fetched opcode.
                    if (i_int_pending && i_ime) begin
                        state_d = S_INT;
                        idx_d   = '0;
                        halt_d  = 1'b0;
                    end else if (halt_q) begin
                        state_d = S_HALT;
                        idx_d   = '0;
                        halt_d  = 1'b0;
                    end else begin
                        halt_d      = i_halt_req;
                        start_instr = 1'b1;
                    end
                end
                S_EXEC: begin
                    halt_d = halt_q | i_halt_req;
                    if (idx_q == n_q - MCYC_W'(1)) begin
                        state_d = S_FETCH;
                        idx_d   = '0;
                    end else begin
                        idx_d = idx_q + MCYC_W'(1);
                    end
                end
                S_INT: begin
                    if (idx_q == MCYC_W'(INT_MCYCLES - 1)) begin
                        state_d = S_BOOT;
                        idx_d   = '0;
                    end else begin
                        idx_d = idx_q + MCYC_W'(1);
                    end
                end
                S_HALT: begin
                    if (i_int_pending) begin
                        state_d = i_ime ? S_INT : S_BOOT;
                        idx_d   = '0;
                    end
                end
                default: begin
                    state_d = S_BOOT;
                    idx_d   = '0;
                end
            endcase

            // Fetch strobe: the opcode on the bus sets the length of the next instruction.
            if (start_instr) begin
                n_d = n_new;
                if (n_new == MCYC_W'(1)) begin
                    state_d = S_FETCH;
                    idx_d   = '0;
                end else begin
                    state_d = S_EXEC;
                    idx_d   = MCYC_W'(1);
                end
            end
        end
    end

    assign o_mcycle_strobe = strobe;
    assign o_fetch_cycle   = (state_q == S_BOOT) || (state_q == S_FETCH);
    assign o_execute_cycle = (state_q == S_EXEC);
    assign o_execute_last  = (state_q == S_FETCH);
    assign o_mcycle_idx    = idx_q;
    assign o_int_dispatch  = (state_q == S_INT);
    assign o_halted        = (state_q == S_HALT);

endmodule

// File: tb/tb_sm83_mcycle_seq.sv
// Bench for sm83_mcycle_seq: a queue of planned M-cycles predicts every output on every clk.
module tb_sm83_mcycle_seq;

    localparam int T    = 4;
    localparam int MAXM = 6;
    localparam int INTM = 5;
    localparam int K_BOOT = 0, K_FETCH = 1, K_EXEC = 2, K_INT = 3, K_HALT = 4;
    localparam logic [10:0] RESET_VEC = 11'h080;

    typedef struct {
        int kind;
        int idx;
    } mc_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       bus_ready = 1'b1;
    logic [2:0] mcycles = 3'd1;
    logic       halt_req = 1'b0;
    logic       int_pending = 1'b0;
    logic       ime = 1'b0;

    logic [1:0]  tstate;
    logic        strobe, fetch, exec_c, exec_last, int_d, halted;
    logic [2:0]  idx;
    logic [10:0] dut_vec;

    int checks = 0;
    int failures = 0;

    mc_t plan[$];
    int  m_t;
    bit  m_halt;

    always #5 clk = ~clk;

    sm83_mcycle_seq dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .i_bus_ready     (bus_ready),
        .i_mcycles       (mcycles),
        .i_halt_req      (halt_req),
        .i_int_pending   (int_pending),
        .i_ime           (ime),
        .o_tstate        (tstate),
        .o_mcycle_strobe (strobe),
        .o_fetch_cycle   (fetch),
        .o_execute_cycle (exec_c),
        .o_execute_last  (exec_last),
        .o_mcycle_idx    (idx),
        .o_int_dispatch  (int_d),
        .o_halted        (halted)
    );

    assign dut_vec = {tstate, strobe, fetch, exec_c, exec_last, idx, int_d, halted};

    // ---------------- reference model: queue of upcoming M-cycles ----------------
    function automatic void model_reset();
        plan.delete();
        plan.push_back('{K_BOOT, 0});
        m_t    = 0;
        m_halt = 1'b0;
    endfunction

    function automatic bit m_strobe();
        return (m_t == T - 1) && bus_ready;
    endfunction

    function automatic logic [10:0] exp_vec();
        mc_t c;
        c = plan[0];
        return {2'(m_t), m_strobe(), (c.kind == K_BOOT || c.kind == K_FETCH), (c.kind == K_EXEC),
                (c.kind == K_FETCH), 3'(c.idx), (c.kind == K_INT), (c.kind == K_HALT)};
    endfunction

    function automatic void plan_dispatch();
        for (int i = 0; i < INTM; i++) plan.push_back('{K_INT, i});
        plan.push_back('{K_BOOT, 0});
    endfunction

    function automatic void plan_instruction();
        int n;
        n = (mcycles == 0) ? 1 : ((int'(mcycles) > MAXM) ? MAXM : int'(mcycles));
        for (int i = 1; i < n; i++) plan.push_back('{K_EXEC, i});
        plan.push_back('{K_FETCH, 0});
    endfunction

    function automatic void model_step();
        mc_t cur;
        if (m_strobe()) begin
            cur = plan.pop_front();
            if (cur.kind == K_FETCH && int_pending && ime) begin
                m_halt = 1'b0;
                plan_dispatch();
            end else if (cur.kind == K_FETCH && m_halt) begin
                m_halt = 1'b0;
                plan.push_back('{K_HALT, 0});
            end else if (cur.kind == K_BOOT || cur.kind == K_FETCH) begin
                if (halt_req) m_halt = 1'b1;
                plan_instruction();
            end else if (cur.kind == K_EXEC) begin
                if (halt_req) m_halt = 1'b1;
            end else if (cur.kind == K_HALT) begin
                if (int_pending && ime) plan_dispatch();
                else if (int_pending) plan.push_back('{K_BOOT, 0});
                else plan.push_back('{K_HALT, 0});
            end
        end
        if (m_t != T - 1) m_t++;
        else if (bus_ready) m_t = 0;
    endfunction

    task automatic tick();
        @(posedge clk);
        if (!rst_n) model_reset();
        else model_step();
        #1;
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        bus_ready = 1'b1; mcycles = 3'd1; halt_req = 1'b0; int_pending = 1'b0; ime = 1'b0;
        #1;
        model_reset();
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        model_reset();
        for (int c = 0; c < 3; c++) begin
            bus_ready = 1'($urandom_range(0, 1));
            #3;
            checks++;
            if (dut_vec !== RESET_VEC) begin
                failures++;
                $display("FAIL reset_state c=%0d got=%h exp=%h", c, dut_vec, RESET_VEC);
            end
            tick();
        end
    endtask

    task automatic test_fetch_stream();
        int strobes = 0;
        apply_reset();
        for (int c = 0; c < 16; c++) begin
            #3;
            checks++;
            if (dut_vec !== exp_vec()) begin
                failures++;
                $display("FAIL fetch_model c=%0d got=%h exp=%h", c, dut_vec, exp_vec());
            end
            checks++;
            if (fetch !== 1'b1 || exec_last !== (c >= 4)) begin
                failures++;
                $display("FAIL fetch_qual c=%0d got=%b%b exp=1%b", c, fetch, exec_last, (c >= 4));
            end
            if (strobe) strobes++;
            tick();
        end
        checks++;
        if (strobes != 4) begin
            failures++;
            $display("FAIL fetch_strobes got=%0d exp=4", strobes);
        end
    endtask

    task automatic test_multi_mcycle();
        apply_reset();
        for (int c = 0; c < 20; c++) begin
            mcycles = (c <= 3) ? 3'd3 : 3'd1;
            #3;
            checks++;
            if (dut_vec !== exp_vec()) begin
                failures++;
                $display("FAIL multi_model c=%0d got=%h exp=%h", c, dut_vec, exp_vec());
            end
            checks++;
            if (strobe !== (c % 4 == 3)) begin
                failures++;
                $display("FAIL multi_strobe c=%0d got=%b exp=%b", c, strobe, (c % 4 == 3));
            end
            if (c == 5 || c == 9) begin
                checks++;
                if (exec_c !== 1'b1 || idx !== 3'((c - 1) / 4)) begin
                    failures++;
                    $display("FAIL multi_exec c=%0d got=%b/%0d exp=1/%0d", c, exec_c, idx, (c - 1) / 4);
                end
            end
            if (c == 13) begin
                checks++;
                if (exec_last !== 1'b1 || fetch !== 1'b1 || idx !== 3'd0) begin
                    failures++;
                    $display("FAIL multi_last got=%b%b/%0d exp=11/0", exec_last, fetch, idx);
                end
            end
            tick();
        end
    endtask

    task automatic test_wait_states();
        apply_reset();
        for (int c = 0; c < 12; c++) begin
            bus_ready = !(c == 1 || (c >= 3 && c <= 5));
            #3;
            checks++;
            if (dut_vec !== exp_vec()) begin
                failures++;
                $display("FAIL wait_model c=%0d got=%h exp=%h", c, dut_vec, exp_vec());
            end
            if (c == 2) begin
                checks++;
                if (tstate !== 2'd2) begin
                    failures++;
                    $display("FAIL wait_ignored got=%0d exp=2", tstate);
                end
            end
            if (c >= 3 && c <= 5) begin
                checks++;
                if (tstate !== 2'd3 || strobe !== 1'b0 || fetch !== 1'b1 || exec_last !== 1'b0) begin
                    failures++;
                    $display("FAIL wait_hold c=%0d got=%h exp=%h", c, dut_vec, RESET_VEC | 11'h600);
                end
            end
            if (c == 6) begin
                checks++;
                if (strobe !== 1'b1) begin
                    failures++;
                    $display("FAIL wait_slip got=%b exp=1", strobe);
                end
            end
            tick();
        end
    endtask

    task automatic test_interrupt();
        apply_reset();
        ime = 1'b1;
        for (int c = 0; c < 32; c++) begin
            int_pending = (c >= 4 && c <= 8);
            #3;
            checks++;
            if (dut_vec !== exp_vec()) begin
                failures++;
                $display("FAIL int_model c=%0d got=%h exp=%h", c, dut_vec, exp_vec());
            end
            if (c >= 8 && c < 28) begin
                checks++;
                if (int_d !== 1'b1 || fetch !== 1'b0 || idx !== 3'((c - 8) / 4)) begin
                    failures++;
                    $display("FAIL int_dispatch c=%0d got=%b%b/%0d exp=10/%0d", c, int_d, fetch, idx, (c - 8) / 4);
                end
            end
            if (c == 28 || c == 29) begin
                checks++;
                if (fetch !== 1'b1 || exec_last !== 1'b0 || int_d !== 1'b0) begin
                    failures++;
                    $display("FAIL int_boot c=%0d got=%b%b%b exp=100", c, fetch, exec_last, int_d);
                end
            end
            tick();
        end
        apply_reset();
        int_pending = 1'b1;
        ime = 1'b0;
        for (int c = 0; c < 24; c++) begin
            #3;
            checks++;
            if (dut_vec !== exp_vec() || int_d !== 1'b0) begin
                failures++;
                $display("FAIL int_masked c=%0d got=%h exp=%h", c, dut_vec, exp_vec());
            end
            tick();
        end
    endtask

    task automatic test_halt();
        for (int pass = 0; pass < 2; pass++) begin
            apply_reset();
            ime = (pass == 1);
            for (int c = 0; c < 44; c++) begin
                halt_req = (c == 7);
                int_pending = (c >= 16 && c <= 19);
                #3;
                checks++;
                if (dut_vec !== exp_vec()) begin
                    failures++;
                    $display("FAIL halt_model p=%0d c=%0d got=%h exp=%h", pass, c, dut_vec, exp_vec());
                end
                if (c >= 12 && c < 20) begin
                    checks++;
                    if (halted !== 1'b1 || fetch !== 1'b0) begin
                        failures++;
                        $display("FAIL halt_state p=%0d c=%0d got=%b%b exp=10", pass, c, halted, fetch);
                    end
                end
                if (pass == 0 && c >= 20 && c < 24) begin
                    checks++;
                    if (halted !== 1'b0 || fetch !== 1'b1 || exec_last !== 1'b0 || int_d !== 1'b0) begin
                        failures++;
                        $display("FAIL halt_wake_boot c=%0d got=%h", c, dut_vec);
                    end
                end
                if (pass == 1 && c >= 20 && c < 40) begin
                    checks++;
                    if (int_d !== 1'b1 || halted !== 1'b0 || idx !== 3'((c - 20) / 4)) begin
                        failures++;
                        $display("FAIL halt_wake_int c=%0d got=%b%b/%0d exp=10/%0d", c, int_d, halted, idx, (c - 20) / 4);
                    end
                end
                tick();
            end
        end
    endtask

    task automatic test_saturate();
        apply_reset();
        for (int c = 0; c < 36; c++) begin
            mcycles = (c <= 3) ? 3'd0 : ((c <= 7) ? 3'd7 : 3'd1);
            #3;
            checks++;
            if (dut_vec !== exp_vec()) begin
                failures++;
                $display("FAIL sat_model c=%0d got=%h exp=%h", c, dut_vec, exp_vec());
            end
            if (c >= 4 && c < 8) begin
                checks++;
                if (exec_last !== 1'b1 || exec_c !== 1'b0) begin
                    failures++;
                    $display("FAIL sat_zero c=%0d got=%b%b exp=10", c, exec_last, exec_c);
                end
            end
            if (c >= 8 && c < 28) begin
                checks++;
                if (exec_c !== 1'b1 || idx !== 3'((c - 8) / 4 + 1)) begin
                    failures++;
                    $display("FAIL sat_exec c=%0d got=%b/%0d exp=1/%0d", c, exec_c, idx, (c - 8) / 4 + 1);
                end
            end
            if (c >= 28 && c < 32) begin
                checks++;
                if (exec_last !== 1'b1 || exec_c !== 1'b0) begin
                    failures++;
                    $display("FAIL sat_end c=%0d got=%b%b exp=10", c, exec_last, exec_c);
                end
            end
            tick();
        end
    endtask

    task automatic test_reset_mid();
        apply_reset();
        mcycles = 3'd3;
        for (int c = 0; c < 6; c++) tick();
        #1;
        checks++;
        if (tstate !== 2'd2 || exec_c !== 1'b1) begin
            failures++;
            $display("FAIL rstmid_pre got=%0d/%b exp=2/1", tstate, exec_c);
        end
        rst_n = 1'b0;
        #1;
        model_reset();
        checks++;
        if (dut_vec !== RESET_VEC) begin
            failures++;
            $display("FAIL rstmid_async got=%h exp=%h", dut_vec, RESET_VEC);
        end
        tick();
        rst_n = 1'b1;
        mcycles = 3'd1;
        for (int c = 0; c < 8; c++) begin
            #3;
            checks++;
            if (dut_vec !== exp_vec() || tstate !== 2'(c % 4)) begin
                failures++;
                $display("FAIL rstmid_after c=%0d got=%h exp=%h", c, dut_vec, exp_vec());
            end
            tick();
        end
    endtask

    task automatic test_random();
        apply_reset();
        for (int c = 0; c < 800; c++) begin
            bus_ready   = ($urandom_range(0, 3) != 0);
            mcycles     = 3'($urandom_range(0, 7));
            halt_req    = ($urandom_range(0, 7) == 0);
            int_pending = ($urandom_range(0, 5) == 0);
            ime         = 1'($urandom_range(0, 1));
            #3;
            checks++;
            if (dut_vec !== exp_vec()) begin
                failures++;
                $display("FAIL random c=%0d got=%h exp=%h", c, dut_vec, exp_vec());
            end
            tick();
        end
    endtask

    initial begin
        test_reset();
        test_fetch_stream();
        test_multi_mcycle();
        test_wait_states();
        test_interrupt();
        test_halt();
        test_saturate();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
